// File: rtl/rv_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, RMW op codes, mstatus bits.
package rv_csr_pkg;

  // CSR addresses
  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrInstreth  = 12'hC82;

  // funct3[1:0] selects the read-modify-write flavour; funct3[2] selects the zimm operand
  localparam logic [1:0] CsrOpRw = 2'b01;
  localparam logic [1:0] CsrOpRs = 2'b10;
  localparam logic [1:0] CsrOpRc = 2'b11;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;

  localparam logic [31:0] MisaDefault = 32'h4000_1100;

  // New CSR value for a read-modify-write; unknown op codes leave the value unchanged.
  function automatic logic [31:0] csr_rmw(input logic [1:0] op, input logic [31:0] old_val,
                                          input logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CsrOpRw: res = operand;
      CsrOpRs: res = old_val | operand;
      CsrOpRc: res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with half-word write ports; a write wins over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  logic [63:0] cnt_q, cnt_d;

  // Next count: explicit write replaces its half and suppresses the 64-bit increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) cnt_d[31:0]  = wdata;
      if (wr_hi) cnt_d[63:32] = wdata;
    end else if (inc) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 64'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: zero-latency read, RMW write, counters, trap/mret side effects.
module csr_file
  import rv_csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = MisaDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_csr,
  input  logic        csr_read_en,
  input  logic        csr_write_en,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        retire,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [63:0] mcycle, minstret;

  logic        mapped, read_only;
  logic [31:0] old_val, operand, new_val;
  logic        we_pre, we;

  // Address decode: old value, whether the address exists, whether it is read-only.
  always_comb begin
    mapped    = 1'b1;
    read_only = (csr_addr[11:8] == 4'hC) || (csr_addr == CsrMisa);
    old_val   = 32'd0;
    case (csr_addr)
      CsrMstatus:                old_val = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CsrMisa:                   old_val = MISA_VAL;
      CsrMtvec:                  old_val = mtvec_q;
      CsrMscratch:               old_val = mscratch_q;
      CsrMepc:                   old_val = mepc_q;
      CsrMcause:                 old_val = mcause_q;
      CsrMcycle,   CsrCycle:     old_val = mcycle[31:0];
      CsrMcycleh,  CsrCycleh:    old_val = mcycle[63:32];
      CsrMinstret, CsrInstret:   old_val = minstret[31:0];
      CsrMinstreth, CsrInstreth: old_val = minstret[63:32];
      default:                   mapped  = 1'b0;
    endcase
  end

  // RMW operand/result and write gating; set/clear with x0/zimm=0 is a pure read.
  always_comb begin
    operand     = funct3[2] ? {27'd0, rs1_idx} : rs1_data;
    new_val     = csr_rmw(funct3[1:0], old_val, operand);
    we_pre      = is_csr && csr_write_en && ((funct3[1:0] == CsrOpRw) || (rs1_idx != 5'd0));
    illegal_csr = is_csr && (!mapped || (we_pre && read_only));
    we          = we_pre && !illegal_csr;
    csr_rdata   = (is_csr && csr_read_en && !illegal_csr) ? old_val : 32'd0;
  end

  // Next-state for the non-counter CSRs: trap beats mret beats a software write.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (trap_en) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (we && (csr_addr == CsrMstatus)) begin
      mie_d  = new_val[MstatusMie];
      mpie_d = new_val[MstatusMpie];
    end

    if (trap_en) begin
      mepc_d   = trap_pc & 32'hFFFF_FFFC;
      mcause_d = trap_cause;
    end else begin
      if (we && (csr_addr == CsrMepc))   mepc_d   = new_val & 32'hFFFF_FFFC;
      if (we && (csr_addr == CsrMcause)) mcause_d = new_val;
    end

    if (we && (csr_addr == CsrMtvec))    mtvec_d    = new_val & 32'hFFFF_FFFC;
    if (we && (csr_addr == CsrMscratch)) mscratch_d = new_val;
  end

  // CSR state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (we && (csr_addr == CsrMcycle)),
    .wr_hi (we && (csr_addr == CsrMcycleh)),
    .wdata (new_val),
    .cnt   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .wr_lo (we && (csr_addr == CsrMinstret)),
    .wr_hi (we && (csr_addr == CsrMinstreth)),
    .wdata (new_val),
    .cnt   (minstret)
  );

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Randomised + directed bench for csr_file with a queue-based scoreboard and reference model.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_csr, csr_read_en, csr_write_en;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        retire, trap_en, mret;
  logic [31:0] trap_pc, trap_cause;
  logic [31:0] csr_rdata, mtvec_o, mepc_o;
  logic        illegal_csr;

  localparam logic [31:0] ResetMtvec = 32'h0000_0100;

  csr_file #(
    .RESET_MTVEC (ResetMtvec),
    .MISA_VAL    (32'h4000_1100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .is_csr       (is_csr),
    .csr_read_en  (csr_read_en),
    .csr_write_en (csr_write_en),
    .funct3       (funct3),
    .csr_addr     (csr_addr),
    .rs1_idx      (rs1_idx),
    .rs1_data     (rs1_data),
    .retire       (retire),
    .trap_en      (trap_en),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .mret         (mret),
    .csr_rdata    (csr_rdata),
    .illegal_csr  (illegal_csr),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  // Reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending expectation, compare the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("csr_rdata", e.id, csr_rdata, e.rdata);
      chk("illegal_csr", e.id, {31'd0, illegal_csr}, {31'd0, e.ill});
      chk("mtvec_o", e.id, mtvec_o, e.mtvec);
      chk("mepc_o", e.id, mepc_o, e.mepc);
    end
  end

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = ResetMtvec; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_read(input logic [11:0] a, output bit mapped, output bit ro,
                            output logic [31:0] v);
    mapped = 1;
    ro = (a[11:8] == 4'hC) || (a == 12'h301);
    case (a)
      12'h300: begin v = 0; v[3] = m_mie; v[7] = m_mpie; end
      12'h301: v = 32'h4000_1100;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      default: begin mapped = 0; v = 0; end
    endcase
  endtask

  // Evaluates the current inputs: combinational response and the write that would happen.
  task automatic model_eval(output logic [31:0] rd, output bit ill, output bit wr,
                            output logic [31:0] nv);
    bit          mp, ro, wpre;
    logic [31:0] old, op;
    model_read(csr_addr, mp, ro, old);
    op   = funct3[2] ? {27'd0, rs1_idx} : rs1_data;
    wpre = is_csr && csr_write_en && (funct3[1:0] == 2'b01 || rs1_idx != 0);
    ill  = is_csr && (!mp || (wpre && ro));
    wr   = wpre && !ill;
    rd   = (is_csr && csr_read_en && !ill) ? old : 32'd0;
    case (funct3[1:0])
      2'b01:   nv = op;
      2'b10:   nv = old | op;
      2'b11:   nv = old & ~op;
      default: nv = old;
    endcase
  endtask

  task automatic model_commit();
    logic [31:0] rd, nv;
    bit          ill, wr, n_mie, n_mpie;
    logic [63:0] n_cyc, n_ins;
    if (!rst_n) begin
      model_reset();
      return;
    end
    model_eval(rd, ill, wr, nv);
    n_cyc = m_cyc + 64'd1;
    n_ins = retire ? m_ins + 64'd1 : m_ins;
    n_mie = m_mie; n_mpie = m_mpie;
    if (wr) begin
      case (csr_addr)
        12'hB00: n_cyc = {m_cyc[63:32], nv};
        12'hB80: n_cyc = {nv, m_cyc[31:0]};
        12'hB02: n_ins = {m_ins[63:32], nv};
        12'hB82: n_ins = {nv, m_ins[31:0]};
        12'h305: m_mtvec = {nv[31:2], 2'b00};
        12'h340: m_mscratch = nv;
        default: ;
      endcase
    end
    if (trap_en) begin
      n_mpie = m_mie; n_mie = 0;
      m_mepc = {trap_pc[31:2], 2'b00};
      m_mcause = trap_cause;
    end else begin
      if (mret) begin
        n_mie = m_mpie; n_mpie = 1;
      end else if (wr && csr_addr == 12'h300) begin
        n_mie = nv[3]; n_mpie = nv[7];
      end
      if (wr && csr_addr == 12'h341) m_mepc = {nv[31:2], 2'b00};
      if (wr && csr_addr == 12'h342) m_mcause = nv;
    end
    m_mie = n_mie; m_mpie = n_mpie; m_cyc = n_cyc; m_ins = n_ins;
  endtask

  // One clock: drive inputs, push the expected response, then advance the model at the edge.
  task automatic step(input logic ic, input logic re, input logic we, input logic [2:0] f3,
                      input logic [11:0] a, input logic [4:0] rs, input logic [31:0] d,
                      input logic ret, input logic tr, input logic [31:0] tpc,
                      input logic [31:0] tc, input logic mr, input logic rn);
    exp_t        e;
    bit          ill, wr;
    logic [31:0] nv;
    is_csr = ic; csr_read_en = re; csr_write_en = we; funct3 = f3; csr_addr = a;
    rs1_idx = rs; rs1_data = d; retire = ret; trap_en = tr; trap_pc = tpc;
    trap_cause = tc; mret = mr; rst_n = rn;
    model_eval(e.rdata, ill, wr, nv);
    e.ill = ill; e.mtvec = m_mtvec; e.mepc = m_mepc; e.id = step_id;
    step_id++;
    exp_q.push_back(e);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 3'd0, 12'h000, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 1);
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs,
                     input logic [31:0] d);
    step(1, 1, 1, f3, a, rs, d, 0, 0, 32'd0, 32'd0, 0, 1);
  endtask

  logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'h7C0, 12'hC01};
  logic [2:0]  f3_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    is_csr = 0; csr_read_en = 0; csr_write_en = 0; funct3 = 0; csr_addr = 0;
    rs1_idx = 0; rs1_data = 0; retire = 0; trap_en = 0; trap_pc = 0; trap_cause = 0;
    mret = 0; rst_n = 0;
    @(posedge clk);
    model_reset();
    #1;

    // Counter after reset
    for (int i = 0; i < 10; i++) idle();
    csr(3'b010, 12'hB00, 5'd0, 32'd0);
    csr(3'b010, 12'hB80, 5'd0, 32'd0);
    csr(3'b010, 12'hC00, 5'd0, 32'd0);

    // mscratch write then pure read
    csr(3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF);
    csr(3'b010, 12'h340, 5'd0, 32'h1234_5678);
    csr(3'b010, 12'h340, 5'd0, 32'd0);

    // mstatus clear-immediate, mtvec mask
    csr(3'b110, 12'h300, 5'd8, 32'd0);
    csr(3'b111, 12'h300, 5'd8, 32'd0);
    csr(3'b010, 12'h300, 5'd0, 32'd0);
    csr(3'b001, 12'h305, 5'd1, 32'h0000_1003);
    idle();

    // Low-to-high carry, full 64-bit wrap, minstret write during retire
    csr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    csr(3'b001, 12'hB80, 5'd1, 32'h0000_0000);
    csr(3'b010, 12'hB80, 5'd0, 32'd0);
    csr(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF);
    csr(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    csr(3'b010, 12'hB00, 5'd0, 32'd0);
    csr(3'b010, 12'hB80, 5'd0, 32'd0);
    step(1, 1, 1, 3'b001, 12'hB02, 5'd1, 32'h0000_0055, 1, 0, 32'd0, 32'd0, 0, 1);
    step(1, 1, 0, 3'b010, 12'hB02, 5'd0, 32'd0, 1, 0, 32'd0, 32'd0, 0, 1);

    // Read-only and unmapped addresses
    csr(3'b001, 12'hC00, 5'd1, 32'h1111_1111);
    csr(3'b010, 12'hC00, 5'd0, 32'd0);
    csr(3'b001, 12'h301, 5'd0, 32'h0);
    csr(3'b010, 12'h7C0, 5'd0, 32'd0);

    // Trap with concurrent mepc write, then mret, then reset
    csr(3'b110, 12'h300, 5'd8, 32'd0);
    step(1, 1, 1, 3'b001, 12'h341, 5'd1, 32'h0000_0500, 0, 1, 32'h0000_0104, 32'h0000_000B,
         0, 1);
    csr(3'b010, 12'h300, 5'd0, 32'd0);
    csr(3'b010, 12'h342, 5'd0, 32'd0);
    step(0, 0, 0, 3'd0, 12'h0, 5'd0, 32'd0, 0, 0, 32'd0, 32'd0, 1, 1);
    csr(3'b010, 12'h300, 5'd0, 32'd0);
    step(1, 1, 1, 3'b001, 12'h340, 5'd1, 32'hCAFE_0000, 1, 0, 32'd0, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++) csr(3'b010, addr_tab[i], 5'd0, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic ic;
      logic [4:0] rs;
      ic = ($urandom_range(0, 9) < 6);
      rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(ic, ic && ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
           f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 15)], rs, $urandom,
           1'($urandom), ($urandom_range(0, 19) == 0), $urandom, $urandom,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) != 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
